// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM state, default widths and parity reference vector
package parity_pkg;
  typedef enum logic [1:0] {ST_DATA, ST_PAR, ST_OUT} state_t;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_ERR_CNT_W = 8;
  localparam logic [15:0] PARITY_REF = 16'h6996;
endpackage

// File: rtl/parity_frame_checker_if.sv
// parity_frame_checker_if: serial bit input, word output handshake and stats
interface parity_frame_checker_if
  import parity_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
);
  logic bit_in;
  logic bit_valid;
  logic out_ready;
  logic clr_stats;
  logic [DATA_W-1:0] data_out;
  logic parity_err;
  logic out_valid;
  logic busy;
  logic [ERR_CNT_W-1:0] err_count;
  logic overrun;
  modport master (
    input  bit_in, bit_valid, out_ready, clr_stats,
    output data_out, parity_err, out_valid, busy, err_count, overrun
  );
  modport slave (
    output bit_in, bit_valid, out_ready, clr_stats,
    input  data_out, parity_err, out_valid, busy, err_count, overrun
  );
endinterface

// File: rtl/parity_xor_tree.sv
// parity_xor_tree: combinational XOR reduction of a W-bit vector
module parity_xor_tree #(
  parameter int W = 5
) (
  input  logic [W-1:0] d,
  output logic         p
);
  assign p = ^d;
endmodule

// File: rtl/parity_frame_checker.sv
// parity_frame_checker: serial even-parity frame receiver with saturating error stats
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input logic clk,
  input logic rst,
  parity_frame_checker_if.master bus
);
  localparam int IDX_W = $clog2(DATA_W);
  state_t state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [DATA_W-1:0] shreg, shreg_nx, data_q;
  logic [ERR_CNT_W-1:0] err_q;
  logic perr_q, ovr_q, par, last, load;
  parity_xor_tree #(.W(DATA_W + 1)) u_xor (.d({shreg, bus.bit_in}), .p(par));
  assign last = idx == IDX_W'(DATA_W - 1);
  // a handshake cycle with bit_valid starts the next frame at index 1: no bubble
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    shreg_nx = shreg;
    load = 1'b0;
    if (state == ST_DATA && bus.bit_valid) begin
      shreg_nx[idx] = bus.bit_in;
      idx_nx = last ? '0 : idx + IDX_W'(1);
      state_nx = last ? ST_PAR : ST_DATA;
    end else if (state == ST_PAR && bus.bit_valid) begin
      load = 1'b1;
      state_nx = ST_OUT;
    end else if (state == ST_OUT && bus.out_ready) begin
      state_nx = ST_DATA;
      idx_nx = IDX_W'(bus.bit_valid);
      if (bus.bit_valid) shreg_nx[0] = bus.bit_in;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_DATA;
      idx <= '0;
      shreg <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      shreg <= shreg_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      perr_q <= 1'b0;
      err_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (load) begin
        data_q <= shreg;
        perr_q <= par;
      end
      err_q <= bus.clr_stats ? '0 : (load && par && err_q != '1) ? err_q + ERR_CNT_W'(1) : err_q;
      ovr_q <= !bus.clr_stats && (ovr_q || (state == ST_OUT && !bus.out_ready && bus.bit_valid));
    end
  end
  assign bus.data_out = data_q;
  assign bus.parity_err = perr_q;
  assign bus.out_valid = state == ST_OUT;
  assign bus.busy = state == ST_PAR || (state == ST_DATA && idx != '0);
  assign bus.err_count = err_q;
  assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_parity_frame_checker.sv
// tb_parity_frame_checker: directed and randomized checks against a queue-based frame model
module tb_parity_frame_checker;
  import parity_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  parity_frame_checker_if #(.DATA_W(4), .ERR_CNT_W(8)) bus ();
  parity_frame_checker_if #(.DATA_W(4), .ERR_CNT_W(2)) bus2 ();
  parity_frame_checker #(.DATA_W(4), .ERR_CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  parity_frame_checker #(.DATA_W(4), .ERR_CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  int checks = 0;
  int errors = 0;
  bit q[$];
  logic m_hold, m_perr, m_ovr;
  logic [3:0] m_word;
  int m_err, m_err2;
  logic [15:0] pref = PARITY_REF;

  task automatic model_reset();
    q.delete();
    m_hold = 0; m_perr = 0; m_ovr = 0; m_word = 0; m_err = 0; m_err2 = 0;
  endtask

  task automatic model(input logic bv, input logic b, input logic rdy, input logic clr);
    logic [3:0] w;
    if (m_hold) begin
      if (rdy) begin
        m_hold = 0;
        if (bv) q.push_back(b);
      end else if (bv) m_ovr = 1;
    end else if (bv) begin
      if (q.size() == 4) begin
        w = 0;
        foreach (q[i]) w[i] = q[i];
        m_word = w;
        m_perr = logic'((($countones(w) + int'(b)) % 2));
        m_hold = 1;
        q.delete();
        if (m_perr) begin
          if (m_err < 255) m_err++;
          if (m_err2 < 3) m_err2++;
        end
      end else q.push_back(b);
    end
    if (clr) begin m_err = 0; m_err2 = 0; m_ovr = 0; end
  endtask

  task automatic cyc(input logic bv, input logic b, input logic rdy, input logic clr);
    bus.bit_valid = bv; bus.bit_in = b; bus.out_ready = rdy; bus.clr_stats = clr;
    bus2.bit_valid = bv; bus2.bit_in = b; bus2.out_ready = rdy; bus2.clr_stats = clr;
    @(posedge clk);
    model(bv, b, rdy, clr);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    cyc(0, 0, 0, 0);
    model_reset();
    rst = 0;
  endtask

  task automatic send(input logic [3:0] w, input logic p, input logic rdy);
    for (int i = 0; i < 4; i++) cyc(1, w[i], rdy, 0);
    cyc(1, p, rdy, 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", bus.busy); end
    checks++; if (bus.data_out !== 4'h0) begin errors++; $display("FAIL rst_data got %0h want 0", bus.data_out); end
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL rst_perr got %0b want 0", bus.parity_err); end
    checks++; if (bus.err_count !== 8'h0) begin errors++; $display("FAIL rst_err_count got %0d want 0", bus.err_count); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %0b want 0", bus.overrun); end
    checks++; if (bus2.err_count !== 2'h0) begin errors++; $display("FAIL rst_err_count2 got %0d want 0", bus2.err_count); end
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got %0b want 1", bus.busy); end
    do_reset();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0b want 0", bus.busy); end
    send(4'b1101, 1'b1, 0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midreset_valid got %0b want 1", bus.out_valid); end
    checks++; if (bus.data_out !== 4'b1101) begin errors++; $display("FAIL midreset_data got %0h want d", bus.data_out); end
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL midreset_perr got %0b want 0", bus.parity_err); end
    cyc(0, 0, 1, 0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_error();
    for (int i = 0; i < 4; i++) cyc(1, 4'b1101 >> i, 0, 0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL err_early_valid got %0b want 0", bus.out_valid); end
    cyc(1, 0, 0, 0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL err_valid got %0b want 1", bus.out_valid); end
    checks++; if (bus.parity_err !== 1'b1) begin errors++; $display("FAIL err_perr got %0b want 1", bus.parity_err); end
    checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL err_count got %0d want 1", bus.err_count); end
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_sweep();
    cyc(0, 0, 0, 1);
    for (int pass = 0; pass < 2; pass++) begin
      for (int w = 0; w < 16; w++) begin
        send(4'(w), pref[w] ^ pass[0], 1);
        checks++; if (bus.data_out !== 4'(w) || bus.parity_err !== pass[0]) begin errors++; $display("FAIL sweep_word got %0h/%0b want %0h/%0b", bus.data_out, bus.parity_err, w, pass[0]); end
      end
      cyc(0, 0, 1, 0);
      checks++; if (bus.err_count !== 8'(16 * pass)) begin errors++; $display("FAIL sweep_err_count got %0d want %0d", bus.err_count, 16 * pass); end
    end
    checks++; if (bus2.err_count !== 2'd3) begin errors++; $display("FAIL sweep_sat2 got %0d want 3", bus2.err_count); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w;
    logic p;
    cyc(0, 0, 0, 1);
    for (int f = 0; f < 3; f++) begin
      w = 4'($urandom);
      p = 1'($urandom);
      for (int i = 0; i < 5; i++) begin
        cyc(1, (i < 4) ? w[i] : p, 1, 0);
        checks++; if (bus.out_valid !== (i == 4)) begin errors++; $display("FAIL b2b_valid f%0d i%0d got %0b want %0b", f, i, bus.out_valid, i == 4); end
      end
      checks++; if (bus.data_out !== w) begin errors++; $display("FAIL b2b_data got %0h want %0h", bus.data_out, w); end
    end
    cyc(0, 0, 1, 0);
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %0b want 0", bus.overrun); end
  endtask

  task automatic test_stall();
    logic [3:0] w, w2;
    w = 4'($urandom);
    send(w, 1'($urandom), 0);
    for (int i = 0; i < 3; i++) cyc(1, 1'($urandom), 0, 0);
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL stall_overrun got %0b want 1", bus.overrun); end
    checks++; if (bus.data_out !== w || bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got %0h/%0b want %0h/1", bus.data_out, bus.out_valid, w); end
    cyc(0, 0, 1, 1);
    checks++; if (bus.overrun !== 1'b0 || bus.err_count !== 8'd0) begin errors++; $display("FAIL clr_stats got %0b/%0d want 0/0", bus.overrun, bus.err_count); end
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL stall_release got %0b/%0b want 0/0", bus.out_valid, bus.busy); end
    w2 = 4'($urandom);
    send(w2, pref[w2], 0);
    checks++; if (bus.data_out !== w2 || bus.parity_err !== 1'b0) begin errors++; $display("FAIL post_stall got %0h/%0b want %0h/0", bus.data_out, bus.parity_err, w2); end
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_saturation();
    cyc(0, 0, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      send(4'h5, 1'b1, 1);
      checks++; if (bus2.err_count !== 2'((k < 3) ? k : 3)) begin errors++; $display("FAIL sat2 k%0d got %0d want %0d", k, bus2.err_count, (k < 3) ? k : 3); end
      checks++; if (bus.err_count !== 8'(k)) begin errors++; $display("FAIL sat8 k%0d got %0d want %0d", k, bus.err_count, k); end
    end
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      cyc(logic'($urandom_range(0, 9) < 7), 1'($urandom), logic'($urandom_range(0, 9) < 6), logic'($urandom_range(0, 99) < 3));
      checks++; if (bus.out_valid !== m_hold) begin errors++; $display("FAIL rnd_valid n%0d got %0b want %0b", n, bus.out_valid, m_hold); end
      checks++; if (bus.busy !== (q.size() != 0)) begin errors++; $display("FAIL rnd_busy n%0d got %0b want %0b", n, bus.busy, q.size() != 0); end
      checks++; if (bus.err_count !== 8'(m_err) || bus2.err_count !== 2'(m_err2)) begin errors++; $display("FAIL rnd_err_count n%0d got %0d/%0d want %0d/%0d", n, bus.err_count, bus2.err_count, m_err, m_err2); end
      checks++; if (bus.overrun !== m_ovr) begin errors++; $display("FAIL rnd_overrun n%0d got %0b want %0b", n, bus.overrun, m_ovr); end
      if (m_hold) begin
        checks++; if (bus.data_out !== m_word || bus.parity_err !== m_perr) begin errors++; $display("FAIL rnd_word n%0d got %0h/%0b want %0h/%0b", n, bus.data_out, bus.parity_err, m_word, m_perr); end
      end
    end
  endtask

  initial begin
    bus.bit_valid = 0; bus.bit_in = 0; bus.out_ready = 0; bus.clr_stats = 0;
    bus2.bit_valid = 0; bus2.bit_in = 0; bus2.out_ready = 0; bus2.clr_stats = 0;
    model_reset();
    test_reset();
    test_error();
    test_sweep();
    test_back_to_back();
    test_stall();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/parity_frame_checker.md
# parity_frame_checker

Serial-to-parallel frame receiver that sequences an even-parity check over incoming bit streams. It accepts one bit per valid cycle and assembles DATA_W data bits (LSB first) followed by one even-parity bit. It then presents the word with a parity-error flag on a valid/ready output handshake and keeps saturating error statistics. It sits between a serial link front-end and any word-level consumer.

## Interface
- DATA_W, default 4: data bits per frame; legal range ≥ 2.
- ERR_CNT_W, default 8: width of the error counter.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data/parity bit.
- bit_valid  input  1  bit_in is valid this cycle.
- out_ready  input  1  consumer accepts the word this cycle.
- clr_stats  input  1  synchronous clear of err_count and overrun.
- data_out  output  DATA_W  assembled data word; bit 0 is the first bit received.
- parity_err  output  1  XOR of the data bits and the parity bit is 1; qualified by out_valid.
- out_valid  output  1  data_out and parity_err are valid.
- busy  output  1  at least one bit of the current frame has been received.
- err_count  output  ERR_CNT_W  saturating count of frames with parity_err = 1.
- overrun  output  1  sticky flag: a bit arrived while an output word was stalled.

## Operation
- FSM states:
  - DATA: collecting data bits; the index counter runs 0..DATA_W-1.
  - PAR: waiting for the parity bit.
  - OUT: holding the output word.
- Reset state is DATA with index 0.
- Reset values: data_out 0, parity_err 0, out_valid 0, busy 0, err_count 0, overrun 0.
- DATA:
  - On bit_valid, shift bit_in into data bit position [index] and increment index.
  - When index = DATA_W-1 is accepted, move to PAR.
  - No bit_valid means hold; gaps between bits are unlimited.
- PAR:
  - On bit_valid, latch data_out, set parity_err = ^{data, bit_in}, assert out_valid, and move to OUT.
  - If parity_err is 1 and err_count is not at its maximum, increment err_count in the same edge.
- OUT: out_valid stays high and data_out/parity_err stay stable until out_valid && out_ready.
  - out_ready = 1: handshake completes and the state returns to DATA, index 0. If bit_valid is also 1 that cycle, the bit is accepted as data bit 0 (index becomes 1). This gives zero bubble between frames.
  - out_ready = 0 and bit_valid = 1: the bit is dropped and overrun sets. The frame in OUT is unaffected.
- busy = 1 in PAR, and in DATA with index > 0. It is 0 in OUT unless a bit was accepted on the handshake edge.
- err_count saturates at 2^ERR_CNT_W-1; it never wraps.
- clr_stats zeroes err_count and overrun. It wins over a simultaneous increment or overrun set. It does not affect the FSM or data.
- rst at any point, including mid-frame or in OUT, discards the partial or held frame and returns all outputs to their reset values on that edge.

## Timing
- A bit is sampled on the edge where bit_valid = 1.
- Latency: out_valid rises on the edge that samples the parity bit and is visible the following cycle.
- Minimum frame period: DATA_W+1 cycles with out_ready held high, including back-to-back frames.
- Handshake: out_valid never drops without out_ready, and data_out never changes while out_valid is high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `parity_pkg`:
  - FSM state enum (ST_DATA, ST_PAR, ST_OUT).
  - Default width constants.
  - The 16-bit even-parity reference vector 16'h6996 used by benches; bit i is the parity of i.
- One sub-module, `parity_xor_tree`: combinational XOR reduction, parameterised by width. It is instantiated with width DATA_W+1 to compute parity_err.
- The FSM, index counter, shift register and stats counters live in the top module.

## Test plan
- Reset mid-frame: send 2 data bits, assert rst for 1 cycle, then send a full frame 1,0,1,1,p=1. Required: data_out = 4'b1101, parity_err = 0, and no residue from the aborted frame.
- Error detect: send 1,0,1,1,p=0. Required: out_valid the cycle after the parity edge, parity_err = 1, err_count = 1.
- Sweep: send all 16 words with parity taken from 16'h6996 (correct), then all 16 with the parity inverted. Required: 0 errors after the first pass, err_count = 16 after the second.
- Back-to-back: hold out_ready = 1 and send 3 frames contiguously. Required: out_valid pulses every 5 cycles, no overrun, data matches each frame.
- Stall/overrun: hold out_ready = 0 in OUT, pulse bit_valid. Required: overrun = 1 and data_out unchanged. Then assert clr_stats and out_ready. Required: overrun = 0, err_count = 0, state returns to DATA.
- Saturation with ERR_CNT_W = 2: send 5 bad frames. Required: err_count stops at 3.
